// File: rtl/rtype_issue_stage.sv
// R-type decode/issue stage: 32x32 register file, RAW/WAW scoreboard, writeback bypass.
// Optional macro ILLEGAL_FUNCT_TRAP_EN traps non-R-type / unknown-funct words.
module rtype_issue_stage #(
   parameter int REG_CNT = 32,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          src_data,
   output logic [DATA_W-1:0]          tar_data,
   output logic [4:0]                 shamt,
   output logic [5:0]                 funct,
   output logic [$clog2(REG_CNT)-1:0] dst_addr,
   input  logic                       wb_en,
   input  logic [$clog2(REG_CNT)-1:0] wb_addr,
   input  logic [DATA_W-1:0]          wb_data
`ifdef ILLEGAL_FUNCT_TRAP_EN
   ,
   output logic                       illegal_funct
`endif
);

   localparam int AW = $clog2(REG_CNT);

   logic [DATA_W-1:0]  rf [REG_CNT];
   logic [REG_CNT-1:0] pend;
   logic [REG_CNT-1:0] pend_nxt;

   logic [5:0]    i_op;
   logic [AW-1:0] i_rs;
   logic [AW-1:0] i_rt;
   logic [AW-1:0] i_rd;
   logic [4:0]    i_sh;
   logic [5:0]    i_fn;

   assign i_op = instr[31:26];
   assign i_rs = instr[21 +: AW];
   assign i_rt = instr[16 +: AW];
   assign i_rd = instr[11 +: AW];
   assign i_sh = instr[10:6];
   assign i_fn = instr[5:0];

   logic wb_hit;
   logic hazard;
   logic accept;
   logic legal;
   logic issue;

   assign wb_hit = wb_en && (wb_addr != '0);

   // A same-cycle writeback to the register releases its pending bit early.
   function automatic logic busy(input logic [AW-1:0] a);
      busy = (a != '0) && pend[a] && !(wb_hit && (wb_addr == a));
   endfunction

   function automatic logic [DATA_W-1:0] rd_op(input logic [AW-1:0] a);
      if (a == '0)
         rd_op = '0;
      else if (wb_hit && (wb_addr == a))
         rd_op = wb_data;
      else
         rd_op = rf[a];
   endfunction

   assign hazard   = busy(i_rs) | busy(i_rt) | busy(i_rd);
   assign in_ready = (!out_valid | out_ready) & !hazard;
   assign accept   = in_valid & in_ready;

`ifdef ILLEGAL_FUNCT_TRAP_EN
   logic fn_ok;

   always_comb begin
      fn_ok = 1'b0;
      unique case (1'b1)
         i_fn == 6'b001001: fn_ok = 1'b1;
         i_fn == 6'b001010: fn_ok = 1'b1;
         i_fn == 6'b010010: fn_ok = 1'b1;
         i_fn == 6'b100010: fn_ok = 1'b1;
         default:           fn_ok = 1'b0;
      endcase
   end

   assign legal = fn_ok && (i_op == 6'd0);
`else
   logic unused_op;

   assign unused_op = ^i_op;
   assign legal     = 1'b1;
`endif

   assign issue = accept & legal;

   // Issue sets its rd after the writeback clear, so set wins on a collision.
   always_comb begin
      pend_nxt = pend;
      if (wb_hit)
         pend_nxt[wb_addr] = 1'b0;
      if (issue && (i_rd != '0))
         pend_nxt[i_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++)
            rf[i] <= '0;
         pend <= '0;
      end else begin
         if (wb_hit)
            rf[wb_addr] <= wb_data;
         pend <= pend_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         src_data  <= '0;
         tar_data  <= '0;
         shamt     <= '0;
         funct     <= '0;
         dst_addr  <= '0;
      end else if (issue) begin
         out_valid <= 1'b1;
         src_data  <= rd_op(i_rs);
         tar_data  <= rd_op(i_rt);
         shamt     <= i_sh;
         funct     <= i_fn;
         dst_addr  <= i_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ILLEGAL_FUNCT_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_funct <= 1'b0;
      else
         illegal_funct <= accept & !legal;
   end
`endif

endmodule
